pipe_reg_n: RTL



---
 rtl/pipe_reg_n.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_reg_n.sv
// pipe_reg_n: elastic WIDTH x DEPTH register pipeline with valid/ready handshake,
// bubble collapse and synchronous flush. Define PIPE_REG_N_OCC_EN to add the occ port.
module pipe_reg_n #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_N_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   // A stage is ready when it is empty or everything downstream of it can move.
   always_comb begin : ready_chain
      logic acc;
      acc = out_ready;
      rdy = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = acc | ~v_q[i];
         rdy[i] = acc;
      end
   end

   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];

   // Data only moves behind a valid item, so bubbles never overwrite held data.
   always_comb begin
      v_d = v_q;
      for (int i = 0; i < DEPTH; i++) begin
         d_d[i] = d_q[i];
      end
      if (flush) begin
         v_d = '0;
      end else begin
         if (rdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
               d_d[0] = in_data;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               v_d[i] = v_q[i-1];
               if (v_q[i-1]) begin
                  d_d[i] = d_q[i-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

`ifdef PIPE_REG_N_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0] occ_q, occ_d;

   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [OCC_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + OCC_W'(v[i]);
      end
      return n;
   endfunction

   // Counting the next-state vector keeps occ aligned with v_q every cycle.
   always_comb begin
      occ_d = popcount(v_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;
`endif

endmodule
